// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between the in-order
// writeback stage (port A, never back-pressured, always wins) and a buffered
// long-latency producer (port B, queued in a DEPTH-entry FIFO and drained on
// cycles where A does not write). Also exports a pending-write mask for the
// hazard unit, a registered stall request, and a sticky protocol-error flag.
module rf_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        rf_RegWrite,
  output logic [4:0]  rf_Write_register,
  output logic [31:0] rf_Write_data,
  output logic [31:0] pend_mask,
  output logic        stall_req,
  output logic        proto_err
);

  localparam int unsigned     PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [7:0]      STARVE_THR = 8'(STARVE_LIMIT);
  localparam logic [7:0]      AGE_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_A_WIN,
    GNT_B_DRAIN
  } grant_e;

  // FIFO storage: register index and data per entry
  logic [4:0]       fifo_reg_q  [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       age_q, age_d;
  logic             stall_q, stall_d;
  logic             proto_q, proto_d;

  grant_e           grant;
  logic             full, empty;
  logic             push, pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);

  // No pass-through when full: a same-cycle pop does not open a slot.
  assign b_ready = reset && !full;

  // Writes to r0 are accepted from B but never stored.
  assign push    = b_valid && b_ready && (b_reg != 5'd0);
  assign pop     = (grant == GNT_B_DRAIN);

  assign stall_req = stall_q;
  assign proto_err = proto_q;

  // Grant selection: A with a non-zero destination wins, else drain the head.
  always_comb begin
    grant = GNT_IDLE;
    if (reset) begin
      if (a_valid && (a_reg != 5'd0)) begin
        grant = GNT_A_WIN;
      end else if (!empty) begin
        grant = GNT_B_DRAIN;
      end
    end
  end

  // Register-file write port mux driven by the grant.
  always_comb begin
    rf_RegWrite       = 1'b0;
    rf_Write_register = '0;
    rf_Write_data     = '0;
    case (grant)
      GNT_A_WIN: begin
        rf_RegWrite       = 1'b1;
        rf_Write_register = a_reg;
        rf_Write_data     = a_data;
      end
      GNT_B_DRAIN: begin
        rf_RegWrite       = 1'b1;
        rf_Write_register = fifo_reg_q[rd_ptr_q];
        rf_Write_data     = fifo_data_q[rd_ptr_q];
      end
      default: begin
        rf_RegWrite       = 1'b0;
      end
    endcase
  end

  // Pending-write mask over the live FIFO entries (head still shown while popping).
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        pend_mask[fifo_reg_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
    if (!reset) begin
      pend_mask = '0;
    end
  end

  // Next-state for pointers, occupancy, head age, stall and protocol flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    age_d    = age_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Age tracks how long the current head has been waiting; a push into an
    // empty FIFO starts the new head at zero on the following cycle.
    if (pop || empty) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + 8'd1;
    end

    stall_d = (count_d == FULL_CNT) || (age_d >= STARVE_THR);
    proto_d = proto_q || (stall_q && a_valid);
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
      proto_q  <= proto_d;
    end
  end

  // FIFO storage write; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= b_reg;
      fifo_data_q[wr_ptr_q] <= b_data;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenario tasks plus a
// queue scoreboard of accepted port-B writes checked against every cycle's
// register-file output, b_ready and pend_mask.
module tb_rf_write_arbiter;

  localparam int DEPTH = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        rf_RegWrite;
  logic [4:0]  rf_Write_register;
  logic [31:0] rf_Write_data;
  logic [31:0] pend_mask;
  logic        stall_req;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t sbq[$];

  rf_write_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_valid(a_valid),
    .a_reg(a_reg),
    .a_data(a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_reg(b_reg),
    .b_data(b_data),
    .rf_RegWrite(rf_RegWrite),
    .rf_Write_register(rf_Write_register),
    .rf_Write_data(rf_Write_data),
    .pend_mask(pend_mask),
    .stall_req(stall_req),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor, sampled mid-cycle
  logic [31:0] exp_mask;
  logic        exp_ready;
  wr_t         exp_e;
  always @(negedge clk) begin
    exp_ready = reset && (sbq.size() != DEPTH);
    checks++;
    if (b_ready !== exp_ready) begin
      errors++;
      $display("FAIL mon_b_ready got %0b want %0b", b_ready, exp_ready);
    end
    exp_mask = '0;
    if (reset) begin
      foreach (sbq[i]) exp_mask[sbq[i].r] = 1'b1;
    end
    checks++;
    if (pend_mask !== exp_mask) begin
      errors++;
      $display("FAIL mon_pend_mask got %h want %h", pend_mask, exp_mask);
    end
    if (!reset) begin
      checks++;
      if (rf_RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL mon_reset_write got %0b want 0", rf_RegWrite);
      end
      sbq.delete();
    end else if (a_valid && a_reg != 5'd0) begin
      checks++;
      if ({rf_RegWrite, rf_Write_register, rf_Write_data} !== {1'b1, a_reg, a_data}) begin
        errors++;
        $display("FAIL mon_a_write got %0b/%0d/%h want 1/%0d/%h",
                 rf_RegWrite, rf_Write_register, rf_Write_data, a_reg, a_data);
      end
    end else if (sbq.size() != 0) begin
      exp_e = sbq.pop_front();
      checks++;
      if ({rf_RegWrite, rf_Write_register, rf_Write_data} !== {1'b1, exp_e.r, exp_e.d}) begin
        errors++;
        $display("FAIL mon_b_drain got %0b/%0d/%h want 1/%0d/%h",
                 rf_RegWrite, rf_Write_register, rf_Write_data, exp_e.r, exp_e.d);
      end
    end else begin
      checks++;
      if ({rf_RegWrite, rf_Write_register, rf_Write_data} !== {1'b0, 5'd0, 32'd0}) begin
        errors++;
        $display("FAIL mon_idle got %0b/%0d/%h want 0/0/0",
                 rf_RegWrite, rf_Write_register, rf_Write_data);
      end
    end
    if (reset && b_valid && exp_ready && b_reg != 5'd0) begin
      sbq.push_back('{r: b_reg, d: b_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b1; b_reg = 5'd5; b_data = 32'hCAFE0005;
    repeat (3) begin
      tick();
      sample();
      checks++;
      if ({b_ready, rf_RegWrite, stall_req, proto_err} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_held got ready/we/stall/perr=%b want 0000",
                 {b_ready, rf_RegWrite, stall_req, proto_err});
      end
      checks++;
      if (pend_mask !== 32'd0) begin
        errors++;
        $display("FAIL reset_pend got %h want 0", pend_mask);
      end
    end
    tick();
    reset = 1'b1;
    idle_inputs();
    sample();
    checks++;
    if ({b_ready, rf_RegWrite, stall_req, proto_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle got ready/we/stall/perr=%b want 1000",
               {b_ready, rf_RegWrite, stall_req, proto_err});
    end
    checks++;
    if (pend_mask !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle_pend got %h want 0", pend_mask);
    end
  endtask

  task automatic test_b_alone();
    tick();
    b_valid = 1'b1; b_reg = 5'd5; b_data = 32'hDEADBEEF;
    sample();
    checks++;
    if (rf_RegWrite !== 1'b0 || pend_mask !== 32'd0) begin
      errors++;
      $display("FAIL b_alone_c0 got we=%0b pend=%h want 0/0", rf_RegWrite, pend_mask);
    end
    tick();
    idle_inputs();
    sample();
    checks++;
    if (pend_mask !== 32'h20) begin
      errors++;
      $display("FAIL b_alone_pend got %h want 00000020", pend_mask);
    end
    checks++;
    if ({rf_RegWrite, rf_Write_register, rf_Write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL b_alone_write got %0b/%0d/%h want 1/5/deadbeef",
               rf_RegWrite, rf_Write_register, rf_Write_data);
    end
    tick();
    sample();
    checks++;
    if (pend_mask !== 32'd0 || rf_RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL b_alone_c2 got pend=%h we=%0b want 0/0", pend_mask, rf_RegWrite);
    end
  endtask

  task automatic test_a_priority();
    tick();
    b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h33;
    sample();
    for (int i = 1; i <= 3; i++) begin
      tick();
      b_valid = 1'b0;
      a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h11;
      sample();
      checks++;
      if ({rf_RegWrite, rf_Write_register, rf_Write_data} !== {1'b1, 5'd7, 32'h11}) begin
        errors++;
        $display("FAIL a_prio_c%0d got %0b/%0d/%h want 1/7/11",
                 i, rf_RegWrite, rf_Write_register, rf_Write_data);
      end
      checks++;
      if (pend_mask !== 32'h8 || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL a_prio_hold_c%0d got pend=%h stall=%0b want 00000008/0",
                 i, pend_mask, stall_req);
      end
    end
    tick();
    idle_inputs();
    sample();
    checks++;
    if ({rf_RegWrite, rf_Write_register, rf_Write_data} !== {1'b1, 5'd3, 32'h33}) begin
      errors++;
      $display("FAIL a_prio_c4 got %0b/%0d/%h want 1/3/33",
               rf_RegWrite, rf_Write_register, rf_Write_data);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL a_prio_age3_stall got %0b want 0", stall_req);
    end
    tick();
    sample();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h700 + i;
      b_valid = 1'b1; b_reg = 5'(i + 1); b_data = 32'hB000 + i;
      sample();
      checks++;
      if (b_ready !== 1'b1 || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL fill_push%0d got ready=%0b stall=%0b want 1/0", i, b_ready, stall_req);
      end
    end
    tick();
    a_valid = 1'b0;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h9999;
    sample();
    checks++;
    if (b_ready !== 1'b0 || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL fill_full got ready=%0b stall=%0b want 0/1", b_ready, stall_req);
    end
    checks++;
    if (rf_Write_register !== 5'd1 || rf_Write_data !== 32'hB000) begin
      errors++;
      $display("FAIL fill_drain0 got %0d/%h want 1/0000b000", rf_Write_register, rf_Write_data);
    end
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      idle_inputs();
      sample();
      checks++;
      if (rf_RegWrite !== 1'b1 || rf_Write_register !== 5'(i + 1) || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL fill_drain%0d got we=%0b reg=%0d stall=%0b want 1/%0d/0",
                 i, rf_RegWrite, rf_Write_register, stall_req, i + 1);
      end
    end
    tick();
    sample();
    checks++;
    if (rf_RegWrite !== 1'b0 || pend_mask !== 32'd0) begin
      errors++;
      $display("FAIL fill_empty got we=%0b pend=%h want 0/0", rf_RegWrite, pend_mask);
    end
  endtask

  task automatic test_zero_reg();
    tick();
    b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h2222;
    sample();
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFF;
    sample();
    checks++;
    if ({rf_RegWrite, rf_Write_register, rf_Write_data} !== {1'b1, 5'd2, 32'h2222}) begin
      errors++;
      $display("FAIL zero_a_drain got %0b/%0d/%h want 1/2/2222",
               rf_RegWrite, rf_Write_register, rf_Write_data);
    end
    tick();
    idle_inputs();
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'h0BAD;
    sample();
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_b_ready got %0b want 1", b_ready);
    end
    tick();
    idle_inputs();
    sample();
    checks++;
    if (rf_RegWrite !== 1'b0 || pend_mask !== 32'd0) begin
      errors++;
      $display("FAIL zero_b_discard got we=%0b pend=%h want 0/0", rf_RegWrite, pend_mask);
    end
  endtask

  task automatic test_proto_starve();
    int  k;
    bit  seen;
    tick();
    b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h44;
    sample();
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_reg = 5'd8; a_data = 32'h88;
    k = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (stall_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
      k++;
    end
    checks++;
    if (!seen || k != STARVE_LIMIT + 1) begin
      errors++;
      $display("FAIL starve_cycle got seen=%0b k=%0d want 1/%0d", seen, k, STARVE_LIMIT + 1);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_before got %0b want 0", proto_err);
    end
    tick();
    a_valid = 1'b0;
    sample();
    checks++;
    if (proto_err !== 1'b1 || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL proto_set got perr=%0b stall=%0b want 1/1", proto_err, stall_req);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      sample();
      checks++;
      if (proto_err !== 1'b1 || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL proto_sticky%0d got perr=%0b stall=%0b want 1/0", i, proto_err, stall_req);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      a_valid = 1'b1; a_reg = 5'd12; a_data = 32'hC0 + i;
      b_valid = 1'b1; b_reg = 5'(10 + i); b_data = 32'hA0 + i;
      sample();
    end
    tick();
    reset = 1'b0;
    b_valid = 1'b0;
    sample();
    checks++;
    if (pend_mask !== 32'd0 || rf_RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL midrst_held got pend=%h we=%0b want 0/0", pend_mask, rf_RegWrite);
    end
    tick();
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (pend_mask !== 32'd0 || rf_RegWrite !== 1'b0 || proto_err !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after%0d got pend=%h we=%0b perr=%0b want 0/0/0",
                 i, pend_mask, rf_RegWrite, proto_err);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_b_alone();
    test_a_priority();
    test_fill();
    test_zero_reg();
    test_proto_starve();
    test_mid_reset();
    sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (RegWrite / Write_register / Write_data) between two producers:
- the in-order pipeline writeback stage (port A), which cannot be back-pressured and always wins;
- a long-latency producer such as the mul/div unit (port B), which is buffered in a DEPTH-entry FIFO and drained on cycles when A does not write.

The block also exports a pending-write mask for the hazard unit and a stall request that forces bubbles in A when B is starving or full. It sits between WB/mul-div and the register file.

## Interface
- DEPTH, 4: port-B FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: cycles the FIFO head may wait before a stall is requested; 1..255.

- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low (0 = reset), sampled on posedge clk.
- a_valid  input  1  WB stage writes this cycle.
- a_reg  input  5  WB destination register.
- a_data  input  32  WB data.
- b_valid  input  1  port-B request.
- b_ready  output  1  port-B accept; transfer when b_valid && b_ready.
- b_reg  input  5  port-B destination.
- b_data  input  32  port-B data.
- rf_RegWrite  output  1  register-file write enable.
- rf_Write_register  output  5  register-file write address.
- rf_Write_data  output  32  register-file write data.
- pend_mask  output  32  bit r = 1 if any valid FIFO entry targets register r; bit 0 always 0.
- stall_req  output  1  registered; pipeline must hold a_valid = 0 while it is 1.
- proto_err  output  1  sticky; set if a_valid = 1 while stall_req = 1.

## Operation
- FIFO state: DEPTH entries of {reg, data}, read/write pointers with wrap-around, occupancy count 0..DEPTH.
- b_ready = reset && (count != DEPTH). There is no pass-through when full, even if a dequeue happens the same cycle.
- On a B transfer with b_reg = 0, the request is accepted and discarded, not enqueued.
- Grant is combinational, with priority in this order:
  - A_WIN: a_valid && a_reg != 0. Outputs = {1, a_reg, a_data}.
  - B_DRAIN: otherwise, if count != 0. Outputs = {1, head.reg, head.data}, and the head is popped at the edge.
  - IDLE: otherwise, outputs = {0, 0, 0}.
- a_valid with a_reg = 0 does not consume the port, so B may drain that cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push into an empty FIFO is not visible at the outputs until the next cycle; minimum B latency is 1 cycle.
- Age counter, 8 bits, saturating:
  - cleared on reset, on pop, and while count = 0;
  - otherwise increments each cycle the head is present and not popped.
- stall_req <= (count_next == DEPTH) || (age_next >= STARVE_LIMIT). It drops the cycle after the condition clears.
- Ordering hazard: B writes reach the register file after later A writes. The hazard unit must stall any instruction whose source or destination hits pend_mask; this block does not reorder.
- pend_mask is combinational from the current FIFO contents. An entry being popped this cycle is still shown until the edge.
- proto_err: set on any cycle with stall_req && a_valid; cleared only by reset. A still wins that cycle.
- Reset (reset = 0 at an edge):
  - FIFO flushed; count, pointers and age = 0; stall_req = 0; proto_err = 0; queued writes are lost.
  - Outputs while reset is held: b_ready = 0, rf_RegWrite = 0, pend_mask = 0.
  - Reset asserted mid-operation behaves identically.

## Timing
- Port A: 0-cycle latency, combinational input to rf_* outputs.
- Port B: ≥1 cycle from accept to rf_RegWrite. The worst case is bounded by STARVE_LIMIT + 1 cycles of stall lead plus queue position.
- stall_req: 1 cycle after the full or aged condition arises.
- Throughput: one register-file write per cycle total; port B sustains 1 write per cycle when A is idle.

## Test plan
- Reset, then idle:
  - rf_RegWrite = 0, b_ready = 1, pend_mask = 0, stall_req = 0.
  - Hold reset = 0 with b_valid = 1 → b_ready = 0, nothing enqueued.
- B alone:
  - Push {r5, 0xDEADBEEF} at cycle 0 → pend_mask = 0x20 at cycle 1, rf write r5 = 0xDEADBEEF at cycle 1, pend_mask = 0 at cycle 2.
- A priority:
  - Queue r3, then drive a_valid with r7 = 0x11 for 3 cycles → r7 written each cycle, r3 is written on cycle 4.
  - Age reaches 3 with no stall_req when STARVE_LIMIT = 8.
- Fill and starvation:
  - DEPTH = 4, a_valid held high, 4 pushes → b_ready = 0 after the 4th, stall_req = 1 the next cycle.
  - Bench drops a_valid → 4 drains in order, stall_req = 0 after count < 4 and age reset.
- Zero-register cases:
  - a_valid with a_reg = 0 and a queued entry → the queued entry drains the same cycle.
  - B push with b_reg = 0 → accepted, count unchanged.
- Protocol violation and mid-operation reset:
  - a_valid = 1 while stall_req = 1 → proto_err = 1 and stays 1.
  - reset = 0 with 2 entries queued → pend_mask = 0, and no write of those entries ever occurs.
